// File: rtl/noc_arb_pkg.sv
// Shared types for the wormhole switch allocator of the 5-port mesh router.
// Port numbering is N=0, S=1, W=2, E=3, L=4. Coordinates are carried in
// COORD_MAX_W-bit fields so that yx_route can serve any COORD_W up to that width.
// Narrower coordinates are zero-extended by the caller, which keeps the
// comparison unsigned.
package noc_arb_pkg;

    localparam int NUM_PORTS   = 5;
    localparam int COORD_MAX_W = 16;

    typedef logic [2:0] port_idx_t;

    typedef enum logic [2:0] {
        PORT_N = 3'd0,
        PORT_S = 3'd1,
        PORT_W = 3'd2,
        PORT_E = 3'd3,
        PORT_L = 3'd4
    } port_e;

    typedef enum logic [1:0] {
        IN_IDLE   = 2'd0,
        IN_REQ    = 2'd1,
        IN_ACTIVE = 2'd2
    } in_state_e;

    typedef struct packed {
        logic [COORD_MAX_W-1:0] y;
        logic [COORD_MAX_W-1:0] x;
    } coord_t;

    // Dimension-ordered routing: resolve Y completely before X.
    function automatic port_e yx_route(input coord_t dest, input coord_t pos);
        port_e p;
        if (dest.y < pos.y)      p = PORT_N;
        else if (dest.y > pos.y) p = PORT_S;
        else if (dest.x < pos.x) p = PORT_W;
        else if (dest.x > pos.x) p = PORT_E;
        else                     p = PORT_L;
        return p;
    endfunction

endpackage

// File: rtl/noc_wh_out_arb.sv
// Per-output allocator slice: round-robin pointer, packet lock and owner,
// downstream credit counter and a sticky credit-overflow error flag.
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   req_i[5]         inputs currently requesting this output
//   owner_empty_i    empty flag of the input that owns the lock
//   owner_last_i     the owning input's next flit is its tail
//   credit_i         one credit returned by the downstream router
//   gnt_o[5]         one-hot grant, valid for one cycle while unlocked
//   valid_o          a flit crosses this output this cycle
//   busy_o           output locked to a packet
//   owner_o          index of the owning input (crossbar mux select)
//   err_o            credit returned while already holding CREDITS
module noc_wh_out_arb
    import noc_arb_pkg::*;
#(
    parameter int CREDITS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic                 owner_empty_i,
    input  logic                 owner_last_i,
    input  logic                 credit_i,
    output logic [NUM_PORTS-1:0] gnt_o,
    output logic                 valid_o,
    output logic                 busy_o,
    output logic [2:0]           owner_o,
    output logic                 err_o
);

    localparam int              CNT_W   = $clog2(CREDITS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CREDITS);

    logic             locked_q, locked_d;
    port_idx_t        owner_q, owner_d;
    port_idx_t        ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic      found;
    port_idx_t winner;
    logic      has_credit;
    logic      grant_en;

    // Search starts one past the last winner, so the last winner has lowest priority.
    always_comb begin
        port_idx_t idx;
        idx    = ptr_q;
        found  = 1'b0;
        winner = ptr_q;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = (idx == port_idx_t'(NUM_PORTS - 1)) ? '0 : idx + 3'd1;
            if (!found && req_i[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign has_credit = (cnt_q != '0);
    // Without credit the requests simply stay pending; nobody is locked in.
    assign grant_en   = !locked_q && has_credit && found;
    assign gnt_o      = grant_en ? (NUM_PORTS'(1) << winner) : '0;
    assign valid_o    = locked_q && !owner_empty_i && has_credit;

    always_comb begin
        locked_d = locked_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        err_d    = err_q;

        if (grant_en) begin
            locked_d = 1'b1;
            owner_d  = winner;
            ptr_d    = winner;
        end else if (valid_o && owner_last_i) begin
            locked_d = 1'b0;
        end

        // A simultaneous send and return cancel out.
        case ({credit_i, valid_o})
            2'b10: begin
                if (cnt_q == CNT_MAX) err_d = 1'b1;
                else                  cnt_d = cnt_q + CNT_W'(1);
            end
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            locked_q <= 1'b0;
            owner_q  <= '0;
            ptr_q    <= port_idx_t'(NUM_PORTS - 1);
            cnt_q    <= CNT_MAX;
            err_q    <= 1'b0;
        end else begin
            locked_q <= locked_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign busy_o  = locked_q;
    assign owner_o = owner_q;
    assign err_o   = err_q;

endmodule

// File: rtl/noc_wh_arbiter.sv
// Wormhole switch allocator for the 5-port mesh router. Each input runs a
// small IDLE/REQ/ACTIVE FSM that latches the YX route and packet length from
// the head flit; each output is a noc_wh_out_arb slice that grants
// round-robin, holds the lock for the whole packet and tracks downstream
// credits. HDR_W must be at least 2*COORD_W+LEN_W.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   yx_pos_i          router position {y,x}, static
//   arb_empty_i[5]    input buffer empty, per input
//   arb_header_i      head flit of each input buffer, HDR_W bits per input:
//                     [2*COORD_W-1:0]={dest_y,dest_x}, next LEN_W bits=length
//   arb_credit_i[5]   credit returned by the downstream router, per output
//   arb_read_o[5]     input buffer pop, per input
//   arb_valid_o[5]    flit crosses the output this cycle, per output
//   arb_mux_sel_o     3 bits per output: owning input
//   arb_demux_sel_o   3 bits per input: routed output
//   arb_busy_o[5]     output locked to a packet
//   arb_err_o[5]      sticky credit overflow, per output
module noc_wh_arbiter
    import noc_arb_pkg::*;
#(
    parameter int COORD_W = 4,
    parameter int LEN_W   = 4,
    parameter int HDR_W   = 16,
    parameter int CREDITS = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [2*COORD_W-1:0]     yx_pos_i,
    input  logic [NUM_PORTS-1:0]     arb_empty_i,
    input  logic [NUM_PORTS*HDR_W-1:0] arb_header_i,
    input  logic [NUM_PORTS-1:0]     arb_credit_i,
    output logic [NUM_PORTS-1:0]     arb_read_o,
    output logic [NUM_PORTS-1:0]     arb_valid_o,
    output logic [NUM_PORTS*3-1:0]   arb_mux_sel_o,
    output logic [NUM_PORTS*3-1:0]   arb_demux_sel_o,
    output logic [NUM_PORTS-1:0]     arb_busy_o,
    output logic [NUM_PORTS-1:0]     arb_err_o
);

    coord_t                          pos;
    logic [NUM_PORTS-1:0]            in_req;
    logic [NUM_PORTS-1:0]            in_last;
    logic [NUM_PORTS-1:0]            in_gnt;
    logic [NUM_PORTS*NUM_PORTS-1:0]  req_flat;
    logic [NUM_PORTS*NUM_PORTS-1:0]  gnt_flat;
    logic [NUM_PORTS-1:0]            owner_empty;
    logic [NUM_PORTS-1:0]            owner_last;

    always_comb begin
        pos = '0;
        pos.y[COORD_W-1:0] = yx_pos_i[2*COORD_W-1:COORD_W];
        pos.x[COORD_W-1:0] = yx_pos_i[COORD_W-1:0];
    end

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_in
        in_state_e        state_q, state_d;
        port_idx_t        demux_q, demux_d;
        logic [LEN_W-1:0] rem_q, rem_d;
        logic [HDR_W-1:0] hdr;
        logic [LEN_W-1:0] hdr_len;
        coord_t           dest;
        port_e            route;

        assign hdr     = arb_header_i[gi*HDR_W +: HDR_W];
        assign hdr_len = hdr[2*COORD_W +: LEN_W];

        if (HDR_W > 2*COORD_W + LEN_W) begin : g_hdr_pad
            logic hdr_pad_unused;
            assign hdr_pad_unused = ^hdr[HDR_W-1:2*COORD_W+LEN_W];
        end

        always_comb begin
            dest = '0;
            dest.y[COORD_W-1:0] = hdr[2*COORD_W-1:COORD_W];
            dest.x[COORD_W-1:0] = hdr[COORD_W-1:0];
        end

        assign route = yx_route(dest, pos);

        always_comb begin
            state_d = state_q;
            demux_d = demux_q;
            rem_d   = rem_q;
            case (state_q)
                IN_IDLE: begin
                    if (!arb_empty_i[gi]) begin
                        demux_d = route;
                        // A zero length field still describes a head-only packet.
                        rem_d   = (hdr_len == '0) ? LEN_W'(1) : hdr_len;
                        state_d = IN_REQ;
                    end
                end
                IN_REQ: begin
                    if (in_gnt[gi]) state_d = IN_ACTIVE;
                end
                IN_ACTIVE: begin
                    if (arb_read_o[gi]) begin
                        rem_d = rem_q - LEN_W'(1);
                        if (rem_q == LEN_W'(1)) state_d = IN_IDLE;
                    end
                end
                default: state_d = IN_IDLE;
            endcase
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= IN_IDLE;
                demux_q <= '0;
                rem_q   <= '0;
            end else begin
                state_q <= state_d;
                demux_q <= demux_d;
                rem_q   <= rem_d;
            end
        end

        assign in_req[gi]                = (state_q == IN_REQ);
        assign in_last[gi]               = (rem_q == LEN_W'(1));
        assign arb_demux_sel_o[gi*3 +: 3] = demux_q;
    end

    for (genvar go = 0; go < NUM_PORTS; go++) begin : g_out
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_req
            assign req_flat[go*NUM_PORTS + gi] =
                in_req[gi] && (arb_demux_sel_o[gi*3 +: 3] == 3'(go));
        end

        // The locked owner's buffer state gates the transfer combinationally.
        assign owner_empty[go] = arb_empty_i[arb_mux_sel_o[go*3 +: 3]];
        assign owner_last[go]  = in_last[arb_mux_sel_o[go*3 +: 3]];

        noc_wh_out_arb #(
            .CREDITS (CREDITS)
        ) u_out_arb (
            .clk           (clk),
            .reset         (reset),
            .req_i         (req_flat[go*NUM_PORTS +: NUM_PORTS]),
            .owner_empty_i (owner_empty[go]),
            .owner_last_i  (owner_last[go]),
            .credit_i      (arb_credit_i[go]),
            .gnt_o         (gnt_flat[go*NUM_PORTS +: NUM_PORTS]),
            .valid_o       (arb_valid_o[go]),
            .busy_o        (arb_busy_o[go]),
            .owner_o       (arb_mux_sel_o[go*3 +: 3]),
            .err_o         (arb_err_o[go])
        );
    end

    // An input is owned by at most one output, so OR-ing is collision free.
    always_comb begin
        in_gnt     = '0;
        arb_read_o = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            in_gnt = in_gnt | gnt_flat[o*NUM_PORTS +: NUM_PORTS];
            if (arb_valid_o[o]) arb_read_o[arb_mux_sel_o[o*3 +: 3]] = 1'b1;
        end
    end

endmodule

// File: tb/tb_noc_wh_arbiter.sv
module tb_noc_wh_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  yx_pos;
    logic [4:0]  empty;
    logic [79:0] header;
    logic [4:0]  credit;
    logic [4:0]  read, valid, busy, err;
    logic [14:0] mux, demux;

    always #5 clk = ~clk;

    noc_wh_arbiter #(
        .COORD_W (4),
        .LEN_W   (4),
        .HDR_W   (16),
        .CREDITS (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .yx_pos_i        (yx_pos),
        .arb_empty_i     (empty),
        .arb_header_i    (header),
        .arb_credit_i    (credit),
        .arb_read_o      (read),
        .arb_valid_o     (valid),
        .arb_mux_sel_o   (mux),
        .arb_demux_sel_o (demux),
        .arb_busy_o      (busy),
        .arb_err_o       (err)
    );

    typedef struct {
        int src;
        int tag;
    } exp_t;

    typedef struct {
        int src;
        int dy;
        int dx;
        int len;
        int exp_out;
        int flits;
    } vec_t;

    logic [15:0] inq [5][$];
    exp_t        expq [5][$];
    logic [4:0]  stall;
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          cyc = 0;
    int          tag_ctr = 0;
    int          vcount [5];
    int          lastv [5];

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic drive();
        for (int i = 0; i < 5; i++) begin
            empty[i] = (inq[i].size() == 0) || stall[i];
            if (inq[i].size() != 0) header[i*16 +: 16] = inq[i][0];
            else                    header[i*16 +: 16] = 16'h0;
        end
    endtask

    task automatic apply();
        drive();
        #1;
    endtask

    // Scoreboard: every valid output flit must match the next expected {src, tag}.
    task automatic sample();
        exp_t e;
        int   tagv;
        int   owned;
        for (int o = 0; o < 5; o++) begin
            if (valid[o]) begin
                vcount[o]++;
                lastv[o] = cyc;
                if (expq[o].size() == 0) begin
                    chk($sformatf("sb_unexpected_valid_o%0d", o), expq[o].size(), 1);
                end else begin
                    e = expq[o].pop_front();
                    chk($sformatf("sb_src_o%0d", o), int'(mux[o*3 +: 3]), e.src);
                    chk($sformatf("sb_read_o%0d", o), int'(read[e.src]), 1);
                    tagv = (inq[e.src].size() != 0) ? int'(inq[e.src][0][15:12]) : 99;
                    chk($sformatf("sb_tag_o%0d", o), tagv, e.tag);
                end
            end
        end
        for (int i = 0; i < 5; i++) begin
            if (read[i]) begin
                owned = 0;
                for (int o = 0; o < 5; o++)
                    if (valid[o] && int'(mux[o*3 +: 3]) == i) owned = 1;
                chk($sformatf("read_owner_i%0d", i), owned, 1);
            end
        end
    endtask

    task automatic step();
        logic [4:0]  rd;
        logic [15:0] d;
        @(negedge clk);
        sample();
        rd = read;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 5; i++)
            if (rd[i] && inq[i].size() != 0) d = inq[i].pop_front();
        drive();
        #1;
    endtask

    task automatic push_pkt(input int src, input int dy, input int dx, input int len, input int out);
        int          n;
        logic [3:0]  t4;
        logic [15:0] flit;
        exp_t        e;
        n  = (len == 0) ? 1 : len;
        t4 = 4'(tag_ctr);
        tag_ctr++;
        for (int k = 0; k < n; k++) begin
            flit = (k == 0) ? {t4, 4'(len), 4'(dy), 4'(dx)} : {t4, 12'h000};
            inq[src].push_back(flit);
            e.src = src;
            e.tag = int'(t4);
            expq[out].push_back(e);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            inq[i].delete();
            expq[i].delete();
            vcount[i] = 0;
            lastv[i]  = -1;
        end
        stall  = '0;
        credit = '0;
        drive();
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
        #1;
    endtask

    function automatic bit any_pending();
        for (int i = 0; i < 5; i++)
            if (inq[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic run_idle(input string name, input int maxc);
        int n = 0;
        while ((any_pending() || (|busy)) && n < maxc) begin
            step();
            n++;
        end
        chk({name, "_idle_timeout"}, int'(n < maxc), 1);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_read"},  int'(read),  0);
        chk({name, "_valid"}, int'(valid), 0);
        chk({name, "_busy"},  int'(busy),  0);
        chk({name, "_err"},   int'(err),   0);
        chk({name, "_mux"},   int'(mux),   0);
        chk({name, "_demux"}, int'(demux), 0);
    endtask

    initial begin
        vec_t vt [8];
        int   exp_rd [7];

        // pos = {2,2}; expected outputs derived by hand from the YX rule.
        vt[0] = '{src: 0, dy: 2, dx: 3,  len: 3, exp_out: 3, flits: 3};
        vt[1] = '{src: 1, dy: 0, dx: 2,  len: 2, exp_out: 0, flits: 2};
        vt[2] = '{src: 2, dy: 5, dx: 1,  len: 1, exp_out: 1, flits: 1};
        vt[3] = '{src: 3, dy: 2, dx: 0,  len: 4, exp_out: 2, flits: 4};
        vt[4] = '{src: 4, dy: 2, dx: 2,  len: 2, exp_out: 4, flits: 2};
        vt[5] = '{src: 0, dy: 2, dx: 15, len: 0, exp_out: 3, flits: 1};
        vt[6] = '{src: 1, dy: 1, dx: 7,  len: 2, exp_out: 0, flits: 2};
        vt[7] = '{src: 3, dy: 3, dx: 0,  len: 3, exp_out: 1, flits: 3};

        yx_pos = 8'h22;
        credit = '0;
        stall  = '0;
        reset  = 1'b1;
        drive();
        #1;
        chk_all_zero("por");
        do_reset();

        // Routing / latency vectors.
        for (int v = 0; v < 8; v++) begin
            do_reset();
            push_pkt(vt[v].src, vt[v].dy, vt[v].dx, vt[v].len, vt[v].exp_out);
            apply();
            chk($sformatf("v%0d_rd_c0", v), int'(read), 0);
            step();
            chk($sformatf("v%0d_demux", v), int'(demux[vt[v].src*3 +: 3]), vt[v].exp_out);
            chk($sformatf("v%0d_rd_c1", v), int'(read), 0);
            step();
            chk($sformatf("v%0d_rd_c2", v), int'(read), 1 << vt[v].src);
            chk($sformatf("v%0d_valid_c2", v), int'(valid), 1 << vt[v].exp_out);
            chk($sformatf("v%0d_busy_c2", v), int'(busy), 1 << vt[v].exp_out);
            run_idle($sformatf("v%0d", v), 20);
            chk($sformatf("v%0d_flits", v), vcount[vt[v].exp_out], vt[v].flits);
            chk($sformatf("v%0d_drained", v), expq[vt[v].exp_out].size(), 0);
        end

        // N -> E, len 3: reads in cycles 2..4, busy drops at edge 5.
        do_reset();
        push_pkt(0, 2, 3, 3, 3);
        apply();
        step();
        step();
        for (int c = 2; c < 5; c++) begin
            chk($sformatf("t1_rd_c%0d", c), int'(read[0]), 1);
            chk($sformatf("t1_valid_c%0d", c), int'(valid[3]), 1);
            chk($sformatf("t1_busy_c%0d", c), int'(busy[3]), 1);
            step();
        end
        chk("t1_busy_c5", int'(busy[3]), 0);
        chk("t1_valid_c5", int'(valid), 0);

        // N, S, L heads to L at once: granted N, S, L on successive arbitrations.
        do_reset();
        push_pkt(0, 2, 2, 1, 4);
        push_pkt(1, 2, 2, 1, 4);
        push_pkt(4, 2, 2, 1, 4);
        apply();
        exp_rd = '{0, 0, 1, 0, 2, 0, 16};
        for (int c = 0; c < 7; c++) begin
            chk($sformatf("t2_rd_c%0d", c), int'(read), exp_rd[c]);
            step();
        end
        chk("t2_busy_after", int'(busy[4]), 0);
        credit = 5'b10000;
        step();
        step();
        step();
        credit = '0;
        // Pointer rests on L, so S must beat E; a stale pointer would pick E first.
        push_pkt(1, 2, 2, 1, 4);
        push_pkt(3, 2, 2, 1, 4);
        apply();
        run_idle("t2b", 20);
        chk("t2_drained", expq[4].size(), 0);
        chk("t2_err", int'(err), 0);

        // Len 6 with no credit returns: 4 flits, stall, then 2 credits finish it.
        do_reset();
        push_pkt(0, 2, 3, 6, 3);
        apply();
        for (int c = 0; c < 8; c++) step();
        chk("t3_flits_stalled", vcount[3], 4);
        chk("t3_last_valid", lastv[3], 5);
        chk("t3_busy_stall", int'(busy[3]), 1);
        credit = 5'b01000;
        chk("t3_valid_same_cycle", int'(valid[3]), 0);
        step();
        chk("t3_valid_c9", int'(valid[3]), 1);
        step();
        credit = '0;
        chk("t3_valid_c10", int'(valid[3]), 1);
        step();
        chk("t3_busy_c11", int'(busy[3]), 0);
        chk("t3_flits_total", vcount[3], 6);
        chk("t3_drained", expq[3].size(), 0);
        chk("t3_err", int'(err), 0);

        // Owner bubble: N (len 3) empties for 3 cycles while W waits for E.
        do_reset();
        push_pkt(0, 2, 3, 3, 3);
        push_pkt(2, 2, 3, 1, 3);
        apply();
        step();
        step();
        step();
        stall[0] = 1'b1;
        step();
        for (int c = 4; c < 7; c++) begin
            chk($sformatf("t4_valid_c%0d", c), int'(valid[3]), 0);
            chk($sformatf("t4_busy_c%0d", c), int'(busy[3]), 1);
            chk($sformatf("t4_mux_c%0d", c), int'(mux[3*3 +: 3]), 0);
            chk($sformatf("t4_read_c%0d", c), int'(read), 0);
            if (c == 6) stall[0] = 1'b0;
            step();
        end
        run_idle("t4", 20);
        chk("t4_w_cycle", lastv[3], 9);
        chk("t4_flits", vcount[3], 4);
        chk("t4_drained", expq[3].size(), 0);

        // Credit overflow on an idle output, then async reset mid-packet.
        do_reset();
        credit = 5'b00010;
        chk("t5_err_c0", int'(err), 0);
        step();
        credit = '0;
        chk("t5_err_set", int'(err), 2);
        step();
        chk("t5_err_sticky", int'(err), 2);
        push_pkt(0, 3, 2, 6, 1);
        apply();
        for (int c = 0; c < 8; c++) step();
        chk("t5_flits_capped", vcount[1], 4);
        chk("t5_busy_stall", int'(busy[1]), 1);
        chk("t5_demux_n", int'(demux[2:0]), 1);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("t5_async");
        do_reset();
        push_pkt(0, 3, 2, 4, 1);
        apply();
        run_idle("t5", 20);
        chk("t5_flits_after_reset", vcount[1], 4);
        chk("t5_drained", expq[1].size(), 0);
        chk("t5_err_cleared", int'(err), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
